execute_control: RTL and testbench
==================================

# execute_control

Combined execute/control stage of the RV32I core: selects ALU operands from decoded controls, computes the ALU result, resolves branches/jumps, and forms register, CSR and memory requests. It sits between the decoder (`id`) and the register/CSR file, the store/load buffer (`sb`) and the PC unit. All outputs are registered.

## Interface
- No parameters. Widths: data, instruction and address buses 32, register address 5, CSR address 12, byte select 4.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset: synchronous, active-low.
- inst  in  32  instruction word; ignored by the datapath.
- inst_addr  in  32  PC of the instruction.
- rd_waddr  in  5  destination register.
- csr_waddr  in  12  destination CSR.
- imm  in  32  sign-extended immediate.
- op1_sel  in  2  operand A: 0 zero, 1 rs1, 2 imm, 3 zero.
- op2_sel  in  2  operand B: 0 zero, 1 rs2, 2 inst_addr, 3 imm.
- alu_sel  in  4  0 none (0), 1 add, 2 sub, 3 sll, 4 slt, 5 sltu, 6 xor, 7 srl, 8 sra, 9 or, 10 and, 11 pass A, 12 csr_rdata|A, 13 csr_rdata&~A, 14/15 none (0).
- br_sel  in  3  0 none, 1 jalr, 2 jal, 3 beq, 4 bne, 5 bge/bgeu, 6 blt/bltu, 7 none.
- wb_sel  in  3  0 none, 1 ALU, 2 inst_addr+4, 3 load, 4 none (store), 5 CSR, 6/7 none.
- mem_rw  in  2  0 none, 1 read, 2 write, 3 none.
- byte_sel  in  4  byte mask (1 byte, 3 half, 15 word).
- un_sign  in  1  1 = signed compare/load, 0 = unsigned.
- rs1_rdata, rs2_rdata, csr_rdata  in  32 each  operand data.
- rd_waddr_o  out 5, rd_wdata_o  out 32  register write port.
- csr_waddr_o  out 12, csr_wdata_o  out 32  CSR write port.
- byte_sel_o  out 4, un_sign_o  out 1  pass-through to `sb`.
- mem_re_o  out 1, mem_raddr_o  out 32  load request.
- mem_we_o  out 1, mem_waddr_o  out 32, mem_wdata_o  out 32  store request.
- hold_o  out 1, jump_o  out 1, jump_addr_o  out 32  to PC unit.

## Operation
- A, B per selects; result R per alu_sel, 32-bit wrap-around. Shift amount B[4:0]; sra arithmetic.
- Branch compare on rs1_rdata vs rs2_rdata, signed if un_sign=1.
- Branch taken: jump_o=1, jump_addr_o = inst_addr+imm. jal: always taken, same target. jalr: target (rs1_rdata+imm) & ~1, independent of R.
- Not taken: jump_o=0, jump_addr_o=0.
- Register write:
  - wb_sel 1: rd_wdata_o = R.
  - wb_sel 2: rd_wdata_o = inst_addr+4.
  - wb_sel 3: rd_waddr_o = rd_waddr, rd_wdata_o = 0; load data is written later by `sb`.
  - wb_sel 5: rd_wdata_o = csr_rdata.
  - No writeback: rd_waddr_o = 0 and rd_wdata_o = 0.
- CSR write: wb_sel 5 drives csr_waddr_o = csr_waddr, csr_wdata_o = R. Otherwise both outputs are 0.
- mem_rw 1: mem_re_o=1, mem_raddr_o=R.
- mem_rw 2: mem_we_o=1, mem_waddr_o=R, mem_wdata_o=rs2_rdata.
- Inactive memory address and data outputs are 0.
- hold_o = 1 for mem_rw 1 (load stall).

## Timing
- All outputs are registered on the rising edge of clk. Latency from inputs to outputs is 1 cycle.
- rst=0 at an edge clears every output to 0 on that edge, including mid-operation.
- Inputs held for N cycles produce the same output N times; jump_o repeats.
- No handshake; a new instruction can be accepted every cycle.

## Configuration
- CSR_EN defined: wb_sel 5 and alu_sel 11–13 behave as specified.
- CSR_EN undefined: csr_waddr_o/csr_wdata_o are tied to 0, wb_sel 5 is treated as no writeback, and alu_sel 12/13 yield 0.

## Test plan
- addi: rs1=5, imm=1, op1 1/op2 3/alu 1/wb 1, rd 31 -> next edge rd_waddr_o=31, rd_wdata_o=6, jump_o=0.
- bge then bgeu:
  - bge: rs1=3, rs2=2, un_sign=1, pc=4, imm=0xFFFFF7E0 -> jump_o=1, jump_addr_o=0xFFFFF7E4, rd_waddr_o=0.
  - bgeu: rs1=1, rs2=2, un_sign=0 -> jump_o=0.
- lh: rs1=1, imm=3, mem_rw 1, byte_sel 3 -> mem_re_o=1, mem_raddr_o=4, hold_o=1, byte_sel_o=3.
- sb: rs1=3, imm=0xFFFFF804, rs2=2, mem_rw 2, wb 4 -> mem_we_o=1, mem_waddr_o=0xFFFFF807, mem_wdata_o=2, rd_waddr_o=0.
- lui and auipc:
  - lui: imm=0x5000, op1 2/op2 0 -> rd_wdata_o=0x5000.
  - auipc: pc=0x14, imm=0x6000, op2 2 -> rd_wdata_o=0x6014.
- jalr and reset:
  - jalr: pc=0x18, rs1=1, imm=0xFFFFF807 -> rd_wdata_o=0x1C, jump_o=1, jump_addr_o=0xFFFFF808.
  - Then assert rst=0 -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/execute_control.sv
// execute_control: combined execute/control stage of the RV32I core.
// Selects ALU operands, computes the ALU result, resolves branches and jumps,
// and forms the register, CSR and memory requests. Every output is
// registered, so outputs follow their inputs by one clock.
//
// Optional feature: define CSR_EN to enable CSR writeback (wb_sel 5) and the
// CSR ALU ops (alu_sel 12/13). Without it the CSR write port is tied to 0,
// wb_sel 5 is treated as no writeback and alu_sel 12/13 yield 0.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   inst                     instruction word (not used by the datapath)
//   inst_addr, imm           PC and sign-extended immediate
//   rd_waddr, csr_waddr      destination register / CSR
//   op1_sel, op2_sel         operand A / B selects
//   alu_sel, br_sel, wb_sel  ALU op, branch kind, writeback source
//   mem_rw, byte_sel, un_sign memory access kind, byte mask, signedness
//   rs1_rdata, rs2_rdata, csr_rdata  operand data
//   rd_*_o, csr_*_o          register / CSR write port
//   byte_sel_o, un_sign_o    pass-through to the load/store buffer
//   mem_*_o                  load and store requests
//   hold_o, jump_o, jump_addr_o  to the PC unit
module execute_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    input  logic [4:0]  rd_waddr,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] imm,
    input  logic [1:0]  op1_sel,
    input  logic [1:0]  op2_sel,
    input  logic [3:0]  alu_sel,
    input  logic [2:0]  br_sel,
    input  logic [2:0]  wb_sel,
    input  logic [1:0]  mem_rw,
    input  logic [3:0]  byte_sel,
    input  logic        un_sign,
    input  logic [31:0] rs1_rdata,
    input  logic [31:0] rs2_rdata,
    input  logic [31:0] csr_rdata,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic [3:0]  byte_sel_o,
    output logic        un_sign_o,
    output logic        mem_re_o,
    output logic [31:0] mem_raddr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_waddr_o,
    output logic [31:0] mem_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    logic [31:0] op_a, op_b, alu_res;
    logic [4:0]  shamt;
    logic        br_eq, br_lt, taken;
    logic [31:0] target;

    logic [4:0]  rd_waddr_d;
    logic [31:0] rd_wdata_d;
    logic [11:0] csr_waddr_d;
    logic [31:0] csr_wdata_d;

`ifndef CSR_EN
    logic unused_csr;
    assign unused_csr = ^{csr_waddr, csr_rdata};
`endif
    logic unused_inst;
    assign unused_inst = ^inst;

    assign shamt = op_b[4:0];

    // Operand selection
    always_comb begin
        unique case (op1_sel)
            2'd1:    op_a = rs1_rdata;
            2'd2:    op_a = imm;
            default: op_a = 32'd0;
        endcase
        unique case (op2_sel)
            2'd1:    op_b = rs2_rdata;
            2'd2:    op_b = inst_addr;
            2'd3:    op_b = imm;
            default: op_b = 32'd0;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        case (alu_sel)
            4'd1:  alu_res = op_a + op_b;
            4'd2:  alu_res = op_a - op_b;
            4'd3:  alu_res = op_a << shamt;
            4'd4:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd5:  alu_res = {31'd0, op_a < op_b};
            4'd6:  alu_res = op_a ^ op_b;
            4'd7:  alu_res = op_a >> shamt;
            4'd8:  alu_res = $unsigned($signed(op_a) >>> shamt);
            4'd9:  alu_res = op_a | op_b;
            4'd10: alu_res = op_a & op_b;
            4'd11: alu_res = op_a;
`ifdef CSR_EN
            4'd12: alu_res = csr_rdata | op_a;
            4'd13: alu_res = csr_rdata & ~op_a;
`endif
            default: alu_res = 32'd0;
        endcase
    end

    // Branch resolution compares the register data directly, not the operands
    assign br_eq = (rs1_rdata == rs2_rdata);
    assign br_lt = un_sign ? ($signed(rs1_rdata) < $signed(rs2_rdata))
                           : (rs1_rdata < rs2_rdata);

    always_comb begin
        taken  = 1'b0;
        target = inst_addr + imm;
        case (br_sel)
            3'd1: begin
                taken  = 1'b1;
                target = (rs1_rdata + imm) & ~32'd1;
            end
            3'd2:    taken = 1'b1;
            3'd3:    taken = br_eq;
            3'd4:    taken = !br_eq;
            3'd5:    taken = !br_lt;
            3'd6:    taken = br_lt;
            default: taken = 1'b0;
        endcase
    end

    // Writeback; loads reserve rd here, the data arrives later from the buffer
    always_comb begin
        rd_waddr_d  = 5'd0;
        rd_wdata_d  = 32'd0;
        csr_waddr_d = 12'd0;
        csr_wdata_d = 32'd0;
        case (wb_sel)
            3'd1: begin
                rd_waddr_d = rd_waddr;
                rd_wdata_d = alu_res;
            end
            3'd2: begin
                rd_waddr_d = rd_waddr;
                rd_wdata_d = inst_addr + 32'd4;
            end
            3'd3: rd_waddr_d = rd_waddr;
`ifdef CSR_EN
            3'd5: begin
                rd_waddr_d  = rd_waddr;
                rd_wdata_d  = csr_rdata;
                csr_waddr_d = csr_waddr;
                csr_wdata_d = alu_res;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_waddr_o  <= '0;
            rd_wdata_o  <= '0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
            byte_sel_o  <= '0;
            un_sign_o   <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_raddr_o <= '0;
            mem_we_o    <= 1'b0;
            mem_waddr_o <= '0;
            mem_wdata_o <= '0;
            hold_o      <= 1'b0;
            jump_o      <= 1'b0;
            jump_addr_o <= '0;
        end else begin
            rd_waddr_o  <= rd_waddr_d;
            rd_wdata_o  <= rd_wdata_d;
            csr_waddr_o <= csr_waddr_d;
            csr_wdata_o <= csr_wdata_d;
            byte_sel_o  <= byte_sel;
            un_sign_o   <= un_sign;
            mem_re_o    <= (mem_rw == 2'd1);
            mem_raddr_o <= (mem_rw == 2'd1) ? alu_res : 32'd0;
            mem_we_o    <= (mem_rw == 2'd2);
            mem_waddr_o <= (mem_rw == 2'd2) ? alu_res : 32'd0;
            mem_wdata_o <= (mem_rw == 2'd2) ? rs2_rdata : 32'd0;
            hold_o      <= (mem_rw == 2'd1);
            jump_o      <= taken;
            jump_addr_o <= taken ? target : 32'd0;
        end
    end

endmodule

// File: tb/tb_execute_control.sv
// Directed-vector bench for execute_control with hand-computed expectations.
module tb_execute_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, inst_addr, imm, rs1_rdata, rs2_rdata, csr_rdata;
    logic [4:0]  rd_waddr;
    logic [11:0] csr_waddr;
    logic [1:0]  op1_sel, op2_sel, mem_rw;
    logic [3:0]  alu_sel, byte_sel;
    logic [2:0]  br_sel, wb_sel;
    logic        un_sign;

    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o, csr_wdata_o, mem_raddr_o, mem_waddr_o, mem_wdata_o, jump_addr_o;
    logic [11:0] csr_waddr_o;
    logic [3:0]  byte_sel_o;
    logic        un_sign_o, mem_re_o, mem_we_o, hold_o, jump_o;

    int n_vec = 0;
    int n_err = 0;

    execute_control dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_addr(inst_addr),
        .rd_waddr(rd_waddr), .csr_waddr(csr_waddr), .imm(imm),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_sel(alu_sel), .br_sel(br_sel),
        .wb_sel(wb_sel), .mem_rw(mem_rw), .byte_sel(byte_sel), .un_sign(un_sign),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .csr_rdata(csr_rdata),
        .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
        .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .byte_sel_o(byte_sel_o), .un_sign_o(un_sign_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        inst = 32'h0000_0013; inst_addr = '0; imm = '0;
        rs1_rdata = '0; rs2_rdata = '0; csr_rdata = '0;
        rd_waddr = '0; csr_waddr = '0; op1_sel = '0; op2_sel = '0;
        alu_sel = '0; br_sel = '0; wb_sel = '0; mem_rw = '0;
        byte_sel = '0; un_sign = 1'b0;
    endtask

    // Apply current inputs across one rising edge, then sample away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register-register ALU op with writeback to rd 1
    task automatic alu_rr(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        clear_inputs();
        rs1_rdata = a; rs2_rdata = b; op1_sel = 2'd1; op2_sel = 2'd1;
        alu_sel = op; wb_sel = 3'd1; rd_waddr = 5'd1;
        step();
        check(tag, rd_wdata_o, exp);
    endtask

    task automatic branch(input string tag, input logic [2:0] kind, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic exp_taken);
        clear_inputs();
        inst_addr = 32'h100; imm = 32'h20; rs1_rdata = a; rs2_rdata = b;
        un_sign = sgn; br_sel = kind;
        step();
        check({tag, ".jump"}, 32'(jump_o), 32'(exp_taken));
        check({tag, ".addr"}, jump_addr_o, exp_taken ? 32'h120 : 32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        step();
        check("reset.rd_waddr", 32'(rd_waddr_o), 32'h0);
        check("reset.jump", 32'(jump_o), 32'h0);
        rst = 1'b1;

        // addi x31, x?, 1 with rs1=5
        clear_inputs();
        rs1_rdata = 32'd5; imm = 32'd1; op1_sel = 2'd1; op2_sel = 2'd3;
        alu_sel = 4'd1; wb_sel = 3'd1; rd_waddr = 5'd31;
        step();
        check("addi.rd_waddr", 32'(rd_waddr_o), 32'd31);
        check("addi.rd_wdata", rd_wdata_o, 32'd6);
        check("addi.jump", 32'(jump_o), 32'd0);

        // bge taken, held two cycles so jump_o repeats
        clear_inputs();
        rs1_rdata = 32'd3; rs2_rdata = 32'd2; un_sign = 1'b1; inst_addr = 32'd4;
        imm = 32'hFFFF_F7E0; br_sel = 3'd5; rd_waddr = 5'd7;
        step();
        check("bge.jump", 32'(jump_o), 32'd1);
        check("bge.addr", jump_addr_o, 32'hFFFF_F7E4);
        check("bge.rd_waddr", 32'(rd_waddr_o), 32'd0);
        step();
        check("bge.jump_hold", 32'(jump_o), 32'd1);

        // bgeu not taken
        rs1_rdata = 32'd1; un_sign = 1'b0;
        step();
        check("bgeu.jump", 32'(jump_o), 32'd0);
        check("bgeu.addr", jump_addr_o, 32'd0);

        // lh
        clear_inputs();
        rs1_rdata = 32'd1; imm = 32'd3; op1_sel = 2'd1; op2_sel = 2'd3; alu_sel = 4'd1;
        mem_rw = 2'd1; byte_sel = 4'd3; un_sign = 1'b1; wb_sel = 3'd3; rd_waddr = 5'd9;
        step();
        check("lh.re", 32'(mem_re_o), 32'd1);
        check("lh.raddr", mem_raddr_o, 32'd4);
        check("lh.hold", 32'(hold_o), 32'd1);
        check("lh.byte_sel", 32'(byte_sel_o), 32'd3);
        check("lh.un_sign", 32'(un_sign_o), 32'd1);
        check("lh.rd_waddr", 32'(rd_waddr_o), 32'd9);
        check("lh.rd_wdata", rd_wdata_o, 32'd0);
        check("lh.we", 32'(mem_we_o), 32'd0);

        // sb
        clear_inputs();
        rs1_rdata = 32'd3; imm = 32'hFFFF_F804; rs2_rdata = 32'd2; op1_sel = 2'd1;
        op2_sel = 2'd3; alu_sel = 4'd1; mem_rw = 2'd2; wb_sel = 3'd4; byte_sel = 4'd1;
        rd_waddr = 5'd4;
        step();
        check("sb.we", 32'(mem_we_o), 32'd1);
        check("sb.waddr", mem_waddr_o, 32'hFFFF_F807);
        check("sb.wdata", mem_wdata_o, 32'd2);
        check("sb.rd_waddr", 32'(rd_waddr_o), 32'd0);
        check("sb.hold", 32'(hold_o), 32'd0);
        check("sb.raddr", mem_raddr_o, 32'd0);

        // lui and auipc
        clear_inputs();
        imm = 32'h5000; op1_sel = 2'd2; op2_sel = 2'd0; alu_sel = 4'd1;
        wb_sel = 3'd1; rd_waddr = 5'd2;
        step();
        check("lui.rd_wdata", rd_wdata_o, 32'h5000);
        inst_addr = 32'h14; imm = 32'h6000; op2_sel = 2'd2;
        step();
        check("auipc.rd_wdata", rd_wdata_o, 32'h6014);

        // ALU corners
        alu_rr("sub", 4'd2, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu_rr("sll", 4'd3, 32'd1, 32'd31, 32'h8000_0000);
        alu_rr("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_rr("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_rr("xor", 4'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        alu_rr("srl", 4'd7, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_rr("sra", 4'd8, 32'h8000_0000, 32'h24, 32'hF800_0000);
        alu_rr("or", 4'd9, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        alu_rr("and", 4'd10, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        alu_rr("passa", 4'd11, 32'h1234_5678, 32'h1, 32'h1234_5678);
        alu_rr("none14", 4'd14, 32'h1234_5678, 32'h1, 32'h0);

        // Branch kinds
        branch("beq", 3'd3, 1'b0, 32'd7, 32'd7, 1'b1);
        branch("bne", 3'd4, 1'b0, 32'd7, 32'd7, 1'b0);
        branch("blt", 3'd6, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1);
        branch("bltu", 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        branch("jal", 3'd2, 1'b0, 32'd0, 32'd5, 1'b1);
        branch("none7", 3'd7, 1'b0, 32'd0, 32'd0, 1'b0);

        // CSR path
        clear_inputs();
        csr_rdata = 32'h0000_00F0; rs1_rdata = 32'h0000_000F; op1_sel = 2'd1;
        alu_sel = 4'd12; wb_sel = 3'd5; csr_waddr = 12'h300; rd_waddr = 5'd3;
        step();
`ifdef CSR_EN
        check("csrrs.rd_waddr", 32'(rd_waddr_o), 32'd3);
        check("csrrs.rd_wdata", rd_wdata_o, 32'h0000_00F0);
        check("csrrs.csr_waddr", 32'(csr_waddr_o), 32'h300);
        check("csrrs.csr_wdata", csr_wdata_o, 32'h0000_00FF);
`else
        check("csrrs.rd_waddr", 32'(rd_waddr_o), 32'd0);
        check("csrrs.rd_wdata", rd_wdata_o, 32'd0);
        check("csrrs.csr_waddr", 32'(csr_waddr_o), 32'd0);
        check("csrrs.csr_wdata", csr_wdata_o, 32'd0);
`endif

        // jalr, then reset mid-operation with inputs still applied
        clear_inputs();
        inst_addr = 32'h18; rs1_rdata = 32'd1; imm = 32'hFFFF_F807; br_sel = 3'd1;
        wb_sel = 3'd2; rd_waddr = 5'd1; op1_sel = 2'd1; op2_sel = 2'd3; alu_sel = 4'd1;
        mem_rw = 2'd1; byte_sel = 4'd15; un_sign = 1'b1;
        step();
        check("jalr.rd_wdata", rd_wdata_o, 32'h1C);
        check("jalr.jump", 32'(jump_o), 32'd1);
        check("jalr.addr", jump_addr_o, 32'hFFFF_F808);
        rst = 1'b0;
        step();
        check("rst.rd_waddr", 32'(rd_waddr_o), 32'd0);
        check("rst.rd_wdata", rd_wdata_o, 32'd0);
        check("rst.jump", 32'(jump_o), 32'd0);
        check("rst.jump_addr", jump_addr_o, 32'd0);
        check("rst.mem_re", 32'(mem_re_o), 32'd0);
        check("rst.raddr", mem_raddr_o, 32'd0);
        check("rst.hold", 32'(hold_o), 32'd0);
        check("rst.byte_sel", 32'(byte_sel_o), 32'd0);
        check("rst.un_sign", 32'(un_sign_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
